// File: rtl/shift_deserializer.sv
// Serial-to-parallel word assembler with a one-word holding register.
// A completed word is dropped (and overrun flagged) if the held word is still unconsumed.
module shift_deserializer #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   serial_in,
  input  logic                   shift_en,
  input  logic                   clear,
  input  logic                   data_ready,
  output logic [WIDTH-1:0]       data_out,
  output logic                   data_valid,
  output logic                   overrun,
  output logic [$clog2(WIDTH):0] bit_count
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sh, w_sh_nxt, r_data;
  logic [CW-1:0]    r_cnt;
  logic             r_ovr;
  logic             w_accept, w_done, w_load, w_ovr_set;

  assign w_accept = shift_en & ~clear;
  assign w_done   = w_accept && (r_cnt == CW'(WIDTH - 1));

  // w_sh_nxt already includes this edge's bit, so it is the completed word on w_done.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_sh_nxt = {r_sh[WIDTH-2:0], serial_in};
    end else begin : g_lsb
      assign w_sh_nxt = {serial_in, r_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (shift_en) begin
      r_sh  <= w_sh_nxt;
      r_cnt <= w_done ? '0 : r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_data  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load)         r_data <= w_sh_nxt;
      if (clear)          r_ovr  <= 1'b0;
      else if (w_ovr_set) r_ovr  <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ovr_set   = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_done) begin
          w_load      = 1'b1;
          w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (w_done) begin
          if (data_ready) w_load    = 1'b1;
          else            w_ovr_set = 1'b1;
        end else if (data_ready) begin
          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  assign data_out   = r_data;
  assign data_valid = (r_state == S_FULL);
  assign overrun    = r_ovr;
  assign bit_count  = r_cnt;
endmodule

// File: tb/tb_shift_deserializer.sv
// Directed + random bench: a 32-bit MSB-first and an 8-bit LSB-first instance
// share one input stream and are compared against a bit-list reference model.
module tb_shift_deserializer;
  logic clk = 1'b0, rst_n = 1'b0, serial_in = 1'b0, shift_en = 1'b0, clear = 1'b0, data_ready = 1'b0;
  logic [31:0] d0; logic v0, o0; logic [5:0] c0;
  logic [7:0]  d1; logic v1, o1; logic [3:0] c1;

  always #5 clk = ~clk;

  shift_deserializer #(.WIDTH(32), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .shift_en(shift_en), .clear(clear),
    .data_ready(data_ready), .data_out(d0), .data_valid(v0), .overrun(o0), .bit_count(c0));
  shift_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .shift_en(shift_en), .clear(clear),
    .data_ready(data_ready), .data_out(d1), .data_valid(v1), .overrun(o1), .bit_count(c1));

  int total = 0, bad = 0;

  // Model: list of accepted bits per instance; word formed from the list on completion.
  bit          mb[2][32];
  int          mc[2];
  logic [31:0] mo[2];
  logic        mv[2], mov[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mc[k] = 0; mo[k] = '0; mv[k] = 1'b0; mov[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit sin, input bit en, input bit clr, input bit rdy);
    for (int k = 0; k < 2; k++) begin
      int w; bit done; logic [31:0] word;
      w = (k == 0) ? 32 : 8; done = 1'b0; word = '0;
      if (clr) begin
        mc[k] = 0; mov[k] = 1'b0;
      end else if (en) begin
        mb[k][mc[k]] = sin;
        mc[k]++;
        if (mc[k] == w) begin
          done = 1'b1;
          for (int i = 0; i < w; i++)
            if (k == 0) word[w-1-i] = mb[k][i];
            else        word[i]     = mb[k][i];
          mc[k] = 0;
        end
      end
      if (done) begin
        if (!mv[k] || rdy) begin mo[k] = word; mv[k] = 1'b1; end
        else mov[k] = 1'b1;
      end else if (mv[k] && rdy) begin
        mv[k] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("msb.data", d0, mo[0]);      chk("msb.valid", 32'(v0), 32'(mv[0]));
    chk("msb.ovr", 32'(o0), 32'(mov[0])); chk("msb.cnt", 32'(c0), 32'(mc[0]));
    chk("lsb.data", 32'(d1), mo[1]); chk("lsb.valid", 32'(v1), 32'(mv[1]));
    chk("lsb.ovr", 32'(o1), 32'(mov[1])); chk("lsb.cnt", 32'(c1), 32'(mc[1]));
  endtask

  task automatic step(input bit sin, input bit en, input bit clr, input bit rdy);
    serial_in = sin; shift_en = en; clear = clr; data_ready = rdy;
    @(posedge clk);
    model_edge(sin, en, clr, rdy);
    #1;
    check_all();
  endtask

  // Sends w MSB bit first; ready is asserted only on the final bit (if rdy_last).
  task automatic send_word(input logic [31:0] w, input bit gapped, input bit rdy_last);
    for (int i = 31; i >= 0; i--) begin
      step(w[i], 1'b1, 1'b0, (i == 0) ? rdy_last : 1'b0);
      if (gapped && i != 0 && (i % 8) == 0)
        for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    chk("reset.data", d0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 31 zeros then a one
    send_word(32'h0000_0001, 1'b0, 1'b0);
    chk("ones.data", d0, 32'h0000_0001);
    chk("ones.valid", 32'(v0), 32'd1);
    chk("ones.cnt", 32'(c0), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // gapped all-ones word
    send_word(32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("gap.data", d0, 32'hFFFF_FFFF);
    chk("gap.valid", 32'(v0), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // overrun then clear
    send_word(32'hFF00_00FF, 1'b0, 1'b0);
    send_word(32'h1234_5678, 1'b0, 1'b0);
    chk("ovr.data", d0, 32'hFF00_00FF);
    chk("ovr.flag", 32'(o0), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr.ovr", 32'(o0), 32'd0);
    chk("clr.valid", 32'(v0), 32'd1);

    // ready on the completing edge while full
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(32'hFFFF_FFFF, 1'b0, 1'b0);
    send_word(32'h0000_0000, 1'b0, 1'b1);
    chk("rdycmp.data", d0, 32'h0);
    chk("rdycmp.valid", 32'(v0), 32'd1);
    chk("rdycmp.ovr", 32'(o0), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // async reset after 17 bits
    for (int i = 0; i < 17; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("arst.cnt", 32'(c0), 32'd0);
    #2 rst_n = 1'b1;
    send_word(32'hA5A5_A5A5, 1'b0, 1'b0);
    chk("arst.word", d0, 32'hA5A5_A5A5);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // clear beats shift on the last bit
    for (int i = 0; i < 31; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("clrlast.valid", 32'(v0), 32'd0);
    chk("clrlast.cnt", 32'(c0), 32'd0);

    // random traffic
    for (int n = 0; n < 3000; n++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 2, $urandom_range(0, 9) < 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 Parameter WIDTH, default 32, sets the assembled word width in bits.
REQ-002 Parameter MSB_FIRST, default 1: 1 means the first received bit lands in data_out[WIDTH-1]; 0 means it lands in data_out[0].
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port serial_in, input, 1 bit: serial data bit, sampled when shift_en=1.
REQ-006 Port shift_en, input, 1 bit: bit-valid strobe; one bit is accepted per clk edge with shift_en=1.
REQ-007 Port clear, input, 1 bit: synchronous abort of the word in progress.
REQ-008 Port data_ready, input, 1 bit: the consumer accepts data_out.
REQ-009 Port data_out, output, WIDTH bits: last completed word (holding register).
REQ-010 Port data_valid, output, 1 bit: data_out holds an unconsumed word.
REQ-011 Port overrun, output, 1 bit: sticky flag; a completed word was dropped.
REQ-012 Port bit_count, output, clog2(WIDTH)+1 bits: bits accepted in the current word, 0..WIDTH-1.

Function
REQ-013 Internal shift register and bit counter: each edge with shift_en=1 and clear=0 shifts serial_in in (direction per MSB_FIRST) and increments bit_count.
REQ-014 Word completes on the edge where shift_en=1, clear=0 and bit_count=WIDTH-1; bit_count wraps to 0 on that same edge.
REQ-015 Output buffer FSM has two states:
- EMPTY: data_valid=0.
- FULL: data_valid=1.
REQ-016 EMPTY + word completes -> the completed word (including the bit accepted that edge) is loaded into data_out; the FSM goes to FULL; data_valid=1 the cycle after the final bit.
REQ-017 FULL + data_ready=1 + no completion -> FSM goes to EMPTY; data_out keeps its value.
REQ-018 FULL + data_ready=1 + completion on the same edge -> the new word is loaded; the FSM stays FULL; overrun is unchanged.
REQ-019 FULL + data_ready=0 + completion -> the new word is discarded; data_out and data_valid are unchanged; overrun is set to 1.
REQ-020 data_ready while EMPTY is ignored.
REQ-021 data_out changes only on a load (REQ-016 or REQ-018); it is stable while data_valid=1.
REQ-022 clear=1:
- bit_count and the shift register are set to 0 next edge.
- clear wins over a simultaneous shift_en; that bit is discarded and no completion occurs.
- overrun is cleared.
- data_out, data_valid and the FSM state are unaffected; data_ready handling proceeds normally.
REQ-023 shift_en=0 holds bit_count and the shift register; gaps of any length between bits are legal.
REQ-024 Throughput: back-to-back words with shift_en continuously high are supported; latency from the final bit to data_valid is 1 clk.

Reset
REQ-025 rst_n=0 asynchronously forces:
- data_out=0, data_valid=0, overrun=0, bit_count=0;
- shift register=0;
- FSM=EMPTY.
REQ-026 Reset mid-word discards the partial word; after rst_n deasserts, the next accepted bit is bit 0 of a new word.
REQ-027 Deassertion of rst_n is synchronous to clk externally; the block needs no internal synchronizer.

Verification
REQ-028 WIDTH=32, MSB_FIRST=1: shift in 31 zeros, then a 1, continuously -> data_out=0x00000001 and data_valid=1 one clk after the 32nd bit; bit_count=0.
REQ-029 Send 0xFFFFFFFF with shift_en low for 3 clks between every 8 bits -> data_out=0xFFFFFFFF and data_valid=1; bit_count is held during the gaps.
REQ-030 Word 0xFF0000FF completed with data_ready=0, then a second word 0x12345678 completed with data_ready=0 -> data_out stays 0xFF0000FF and overrun=1. Then clear=1 -> overrun=0 and data_valid stays 1.
REQ-031 data_ready=1 on the exact edge the next word 0x00000000 completes, while FULL with 0xFFFFFFFF -> data_out=0x00000000, data_valid stays 1, overrun=0.
REQ-032 rst_n pulsed low after 17 bits, asynchronously between edges -> all outputs are 0 immediately; a following 32-bit word 0xA5A5A5A5 is assembled correctly.
REQ-033 clear and shift_en both high at bit_count=31 -> no word is produced, data_valid stays 0, bit_count=0.
